// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit engine: command codes, engine states
// and the command decoder.
package i2c_pkg;

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b100;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned PHASES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_t;

  // Illegal codes map to ST_IDLE so the caller can treat them as a no-op.
  function automatic state_t cmd_to_state(input logic [2:0] c);
    case (c)
      CMD_START: return ST_START;
      CMD_STOP:  return ST_STOP;
      CMD_WRITE: return ST_WRITE;
      CMD_READ:  return ST_READ;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: START/STOP/WRITE/READ sequenced in 4 tick phases per bit.
// Optional clock stretching is enabled by defining I2C_STRETCH_EN.
module i2c_bit_engine
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] wr_data,
  input  logic       ack_in,
  output logic [7:0] rd_data,
  output logic       ack_out,
  output logic       done,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  logic [3:0] r_bit, w_bit_nxt;
  logic       r_done, w_done_nxt;
  logic [7:0] r_shift, r_rd_data;
  logic       r_ack_in, r_ack_out;
  logic       r_scl_hold, r_sda_hold;
  logic       w_scl_oe, w_sda_oe;
  logic       w_accept, w_data, w_stall, w_adv, w_bit_end, w_last, w_sample;

  assign cmd_ready = (r_state == ST_IDLE) && !r_done;
  assign w_accept  = cmd_ready && cmd_valid;
  assign w_data    = (r_state == ST_WRITE) || (r_state == ST_READ);

`ifdef I2C_STRETCH_EN
  // A slave holding SCL low freezes the phase in which SCL was released.
  assign w_stall = !scl_in && (r_phase == 2'd1) && (w_data || (r_state == ST_STOP));
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = scl_in;
  assign w_stall         = 1'b0;
`endif

  assign w_adv     = tick && (r_state != ST_IDLE) && !w_stall;
  assign w_bit_end = w_adv && (r_phase == 2'd3);
  assign w_last    = w_bit_end && (!w_data || (r_bit == 4'd8));
  assign w_sample  = w_adv && w_data && (r_phase == 2'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_done_nxt  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_state_nxt = cmd_to_state(cmd);
        w_phase_nxt = '0;
        w_bit_nxt   = '0;
        w_done_nxt  = (cmd_to_state(cmd) == ST_IDLE);
      end
    end else if (w_last) begin
      w_state_nxt = ST_IDLE;
      w_phase_nxt = '0;
      w_bit_nxt   = '0;
      w_done_nxt  = 1'b1;
    end else if (w_bit_end) begin
      w_phase_nxt = '0;
      w_bit_nxt   = r_bit + 4'd1;
    end else if (w_adv) begin
      w_phase_nxt = r_phase + 2'd1;
    end
  end

  // Line drive per phase; while idle the levels left by the last command persist.
  always_comb begin
    w_scl_oe = r_scl_hold;
    w_sda_oe = r_sda_hold;
    case (r_state)
      ST_START: begin
        w_scl_oe = r_phase[1];
        w_sda_oe = (r_phase != 2'd0);
      end
      ST_STOP: begin
        w_scl_oe = (r_phase == 2'd0);
        w_sda_oe = !r_phase[1];
      end
      ST_WRITE: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = (r_bit == 4'd8) ? 1'b0 : ~r_shift[7];
      end
      ST_READ: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = (r_bit == 4'd8) ? ~r_ack_in : 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_rd_data  <= '0;
      r_ack_in   <= 1'b0;
      r_ack_out  <= 1'b1;
      r_scl_hold <= 1'b0;
      r_sda_hold <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift  <= wr_data;
        r_ack_in <= ack_in;
      end
      if (w_sample) begin
        if ((r_state == ST_WRITE) && (r_bit == 4'd8)) begin
          r_ack_out <= sda_in;
        end else if ((r_state == ST_READ) && (r_bit != 4'd8)) begin
          r_shift <= {r_shift[6:0], sda_in};
        end
      end
      if (w_bit_end && (r_state == ST_WRITE)) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      if (w_last) begin
        r_scl_hold <= w_scl_oe;
        r_sda_hold <= w_sda_oe;
        if (r_state == ST_READ) begin
          r_rd_data <= r_shift;
        end
      end
    end
  end

  assign rd_data = r_rd_data;
  assign ack_out = r_ack_out;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);
  assign scl_oe  = w_scl_oe;
  assign sda_oe  = w_sda_oe;

endmodule
